// File: rtl/ecc_secded_pkg.sv
// Shared SEC-DED (39,32) definitions: widths, data-bit placement and the Hamming
// check-bit generator that a matching encoder can reuse.
package ecc_secded_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned HAM_W   = 6;
  localparam int unsigned CHK_W   = 7;
  localparam int unsigned POS_W   = 6;
  localparam int unsigned NUM_POS = 38;

  // Codeword position of each data bit; powers of two are reserved for check bits.
  localparam logic [POS_W-1:0] DATA_POS [DATA_W] = '{
    6'd3,  6'd5,  6'd6,  6'd7,
    6'd9,  6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15,
    6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd23,
    6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd30, 6'd31,
    6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

  typedef enum logic [2:0] {
    CLS_CLEAN,
    CLS_OVERALL,
    CLS_CHECK,
    CLS_DATA,
    CLS_DOUBLE
  } err_cls_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              single_error;
    logic              double_error;
  } dec_result_t;

  // Even-parity Hamming bits: bit i covers every data bit whose position has bit i set.
  function automatic logic [HAM_W-1:0] calc_ham(input logic [DATA_W-1:0] d);
    logic [HAM_W-1:0] h;
    h = '0;
    for (int k = 0; k < DATA_W; k++) begin
      for (int i = 0; i < HAM_W; i++) begin
        if (DATA_POS[k][i]) h[i] = h[i] ^ d[k];
      end
    end
    return h;
  endfunction

endpackage

// File: rtl/ecc_correction_detection_if.sv
// Read-path bundle: received word/check bits in, corrected word and error flags out.
interface ecc_correction_detection_if;
  import ecc_secded_pkg::*;

  logic [DATA_W-1:0] data;
  logic [CHK_W-1:0]  parity;
  logic [DATA_W-1:0] sec_corrected_data;
  logic              single_error;
  logic              double_error;

  modport master (
    output data,
    output parity,
    input  sec_corrected_data,
    input  single_error,
    input  double_error
  );

  modport slave (
    input  data,
    input  parity,
    output sec_corrected_data,
    output single_error,
    output double_error
  );
endinterface

// File: rtl/secded_syndrome.sv
// Combinational syndrome and overall-parity computation for a received codeword.
module secded_syndrome
  import ecc_secded_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [CHK_W-1:0]  parity,
  output logic [HAM_W-1:0]  s,
  output logic              ov
);

  assign s  = parity[HAM_W-1:0] ^ calc_ham(data);
  assign ov = ^{data, parity};

endmodule

// File: rtl/ecc_correction_detection.sv
// SEC-DED decoder: classifies the syndrome, corrects single data-bit errors and
// registers the corrected word with single/double error flags.
module ecc_correction_detection
  import ecc_secded_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  ecc_correction_detection_if.slave   bus
);

  logic [HAM_W-1:0]  s_c;
  logic              ov_c;
  err_cls_t          cls_c;
  logic [DATA_W-1:0] flip_c;
  dec_result_t       res_d;
  dec_result_t       res_q;

  secded_syndrome u_syndrome (
    .data   (bus.data),
    .parity (bus.parity),
    .s      (s_c),
    .ov     (ov_c)
  );

  // Odd overall parity means an odd error count; valid positions are treated as one error.
  always_comb begin
    cls_c = CLS_CLEAN;
    if (ov_c) begin
      if (s_c == '0) begin
        cls_c = CLS_OVERALL;
      end else if ((s_c & (s_c - POS_W'(1))) == '0) begin
        cls_c = CLS_CHECK;
      end else if (s_c <= POS_W'(NUM_POS)) begin
        cls_c = CLS_DATA;
      end else begin
        cls_c = CLS_DOUBLE;
      end
    end else if (s_c != '0) begin
      cls_c = CLS_DOUBLE;
    end
  end

  // Syndrome names the faulty position; map it back onto the data bit it holds.
  always_comb begin
    flip_c = '0;
    for (int k = 0; k < DATA_W; k++) begin
      flip_c[k] = (cls_c == CLS_DATA) && (s_c == DATA_POS[k]);
    end
  end

  always_comb begin
    res_d              = '0;
    res_d.data         = bus.data ^ flip_c;
    res_d.single_error = (cls_c == CLS_OVERALL) || (cls_c == CLS_CHECK) ||
                         (cls_c == CLS_DATA);
    res_d.double_error = (cls_c == CLS_DOUBLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign bus.sec_corrected_data = res_q.data;
  assign bus.single_error       = res_q.single_error;
  assign bus.double_error       = res_q.double_error;

endmodule

// File: tb/tb_ecc_correction_detection.sv
// Scoreboard bench for the SEC-DED decoder with a positional Hamming reference model.
module tb_ecc_correction_detection;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ecc_correction_detection_if bus ();

  ecc_correction_detection dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        se;
    logic        de;
    int          due;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  // Lay out {parity,data} as codeword positions 0..38 (position 0 = overall bit).
  function automatic logic [38:0] build_cw(logic [31:0] d, logic [6:0] p);
    logic [38:0] cw;
    int k = 0;
    int b = 0;
    cw    = '0;
    cw[0] = p[6];
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) == 0) begin
        cw[pos] = p[b];
        b++;
      end else begin
        cw[pos] = d[k];
        k++;
      end
    end
    return cw;
  endfunction

  function automatic logic [31:0] extract(logic [38:0] cw);
    logic [31:0] d;
    int k = 0;
    d = '0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[pos];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [5:0] syn_of(logic [38:0] cw);
    logic [5:0] s;
    s = '0;
    for (int pos = 1; pos <= 38; pos++) begin
      if (cw[pos]) s = s ^ 6'(pos);
    end
    return s;
  endfunction

  function automatic logic [6:0] encode(logic [31:0] d);
    logic [6:0] p;
    p      = '0;
    p[5:0] = syn_of(build_cw(d, 7'h00));
    p[6]   = ^{d, p[5:0]};
    return p;
  endfunction

  task automatic model(input logic [31:0] d, input logic [6:0] p,
                       output logic [31:0] ed, output logic es, output logic ee);
    logic [38:0] cw;
    logic [5:0]  s;
    logic        ov;
    cw = build_cw(d, p);
    s  = syn_of(cw);
    ov = ^cw;
    ed = d;
    es = 1'b0;
    ee = 1'b0;
    if (!ov) begin
      ee = (s != 0);
    end else if (s == 0 || ((s & (s - 6'd1)) == 0)) begin
      es = 1'b1;
    end else if (s <= 6'd38) begin
      cw[s] = ~cw[s];
      ed    = extract(cw);
      es    = 1'b1;
    end else begin
      ee = 1'b1;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] ad, input logic as_, input logic ade,
                       input logic [31:0] xd, input logic xs, input logic xde);
    total++;
    if ({ad, as_, ade} !== {xd, xs, xde}) begin
      bad++;
      $display("FAIL %s @cyc %0d: got data=%h se=%b de=%b, want data=%h se=%b de=%b",
               nm, cyc, ad, as_, ade, xd, xs, xde);
    end
  endtask

  task automatic push(input string nm, input logic [31:0] d, input logic se, input logic de);
    exp_t e;
    e.d    = d;
    e.se   = se;
    e.de   = de;
    e.due  = cyc + 1;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Drive one word on the falling edge; expectation comes from the model.
  task automatic send_model(input string nm, input logic [31:0] d, input logic [6:0] p);
    logic [31:0] ed;
    logic        es, ee;
    @(negedge clk);
    bus.data   = d;
    bus.parity = p;
    model(d, p, ed, es, ee);
    push(nm, ed, es, ee);
  endtask

  task automatic send_const(input string nm, input logic [31:0] d, input logic [6:0] p,
                            input logic [31:0] ed, input logic es, input logic ee);
    @(negedge clk);
    bus.data   = d;
    bus.parity = p;
    push(nm, ed, es, ee);
  endtask

  // Monitor: outputs are checked 1 time unit after the edge they are due on.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check(e.name, bus.sec_corrected_data, bus.single_error, bus.double_error,
              e.d, e.se, e.de);
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [6:0]  p;
    logic [38:0] w;
    int          i1, i2, nflip, waitc;

    bus.data   = $urandom;
    bus.parity = 7'($urandom);

    // Reset holds outputs at zero even while clocks and inputs toggle.
    repeat (3) begin
      @(negedge clk);
      bus.data   = $urandom;
      bus.parity = 7'($urandom);
      @(posedge clk);
      #1;
      check("reset_hold", bus.sec_corrected_data, bus.single_error, bus.double_error,
            32'h0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    send_const("zero_word",   32'h0, 7'h00,       32'h0, 1'b0, 1'b0);
    send_const("data_err_d0", 32'h1, 7'h00,       32'h0, 1'b1, 1'b0);
    send_const("chk_err_p0",  32'h0, 7'b0000001,  32'h0, 1'b1, 1'b0);
    send_const("dbl_data",    32'h3, 7'h00,       32'h3, 1'b0, 1'b1);
    send_const("dbl_mixed_a", 32'h1, 7'b0000010,  32'h1, 1'b0, 1'b1);
    send_const("dbl_mixed_b", 32'h2, 7'b0000001,  32'h2, 1'b0, 1'b1);
    send_const("ovr_err_p6",  32'h0, 7'b1000000,  32'h0, 1'b1, 1'b0);
    send_const("dbl_invalid", 32'h0, 7'b1100111,  32'h0, 1'b0, 1'b1);

    // Single-bit sweep over every codeword bit, one word per cycle.
    d = 32'hDEADBEEF;
    p = encode(d);
    for (int i = 0; i < 39; i++) begin
      w    = {p, d};
      w[i] = ~w[i];
      send_const($sformatf("sweep_bit%0d", i), w[31:0], w[38:32], 32'hDEADBEEF, 1'b1, 1'b0);
    end
    send_const("sweep_clean", d, p, 32'hDEADBEEF, 1'b0, 1'b0);

    // Random words with 0, 1 or 2 flipped bits.
    for (int n = 0; n < 300; n++) begin
      d     = $urandom;
      w     = {encode(d), d};
      nflip = $urandom_range(0, 2);
      i1    = $urandom_range(0, 38);
      i2    = $urandom_range(0, 38);
      while (i2 == i1) i2 = $urandom_range(0, 38);
      if (nflip >= 1) w[i1] = ~w[i1];
      if (nflip == 2) w[i2] = ~w[i2];
      send_model($sformatf("rand%0d_f%0d", n, nflip), w[31:0], w[38:32]);
    end

    // Asynchronous reset mid-stream drops the word in flight.
    d = 32'h1234_5678;
    w = {encode(d), d};
    w[7] = ~w[7];
    send_model("pre_reset", w[31:0], w[38:32]);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_reset", bus.sec_corrected_data, bus.single_error, bus.double_error,
          32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_drop", bus.sec_corrected_data, bus.single_error, bus.double_error,
          32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send_model("post_reset_a", w[31:0], w[38:32]);
    send_const("post_reset_b", 32'hCAFE_F00D, encode(32'hCAFE_F00D), 32'hCAFE_F00D, 1'b0, 1'b0);

    waitc = 0;
    while (exp_q.size() > 0 && waitc < 20) begin
      @(posedge clk);
      waitc++;
    end
    #2;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
